s832_bist_ctrl: RTL and testbench

Built-in self-test controller for the s832 sequential core. Initialises the core's five state flops via G18, drives a programmable number of pseudo-random input patterns onto G0–G16, and compacts the 19 primary outputs into a signature register. Sits beside the s832 instance and owns its input pins whenever a test is in progress.

---
 rtl/s832_bist_pkg.sv | 30 +++
 rtl/s832_misr.sv | 37 +++
 rtl/s832_bist_ctrl.sv | 128 ++++++++++++
 tb/tb_s832_bist_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/s832_bist_pkg.sv
// s832_bist_pkg: shared definitions for the s832 BIST controller and its MISR.
//   - state_e    : controller state encoding (IDLE, INIT, RUN, DONE)
//   - PI_W/PO_W  : core input/output widths
//   - LFSR_W     : pattern generator width
//   - LFSR_SEED  : generator value loaded at the start of every run
//   - MISR_POLY  : Galois feedback taps of the signature register
//   - lfsr_step  : one shift of the x^17+x^14+1 pattern generator
package s832_bist_pkg;

    localparam int PI_W   = 18;
    localparam int PO_W   = 19;
    localparam int LFSR_W = 17;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 17'h00001;
    localparam logic [PO_W-1:0]   MISR_POLY = 19'h00047;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Fibonacci form, feedback taps at bits 16 and 13; maximal length, so
    // it never reaches all-zero from a non-zero seed.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[16] ^ l[13]};
    endfunction

endpackage

// File: rtl/s832_misr.sv
// s832_misr: 19-bit Galois multiple-input signature register.
// Ports:
//   CK       in   clock, state updates on the falling edge
//   RST      in   asynchronous active-high reset, clears the signature
//   clr      in   synchronous clear (takes priority over en)
//   en       in   compact po into the signature this edge
//   po       in   19-bit word to compact
//   sig      out  current signature
//   sig_next out  value the signature takes on the next enabled edge
module s832_misr
    import s832_bist_pkg::*;
(
    input  logic            CK,
    input  logic            RST,
    input  logic            clr,
    input  logic            en,
    input  logic [PO_W-1:0] po,
    output logic [PO_W-1:0] sig,
    output logic [PO_W-1:0] sig_next
);

    assign sig_next = {sig[PO_W-2:0], 1'b0} ^ (sig[PO_W-1] ? MISR_POLY : '0) ^ po;

    // NOTE: state registers use non-blocking assignments so every flop on
    // this edge samples pre-edge values; the reset is in the sensitivity
    // list, which is what makes it asynchronous.
    always_ff @(negedge CK or posedge RST) begin
        if (RST) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/s832_bist_ctrl.sv
// s832_bist_ctrl: BIST controller for the s832 core. Clears the core flops
// through G18, applies N_PAT pseudo-random patterns on G0..G16 and compacts
// the core outputs into a signature.
// Optional feature: define S832_BIST_GOLDEN_CMP_EN to add the PASS output,
// which compares the final signature against GOLDEN_SIG.
// Ports:
//   CK     in   clock, all registers update on the falling edge
//   RST    in   asynchronous active-high reset
//   START  in   run request, sampled in IDLE and DONE
//   PO     in   19 core outputs
//   PI     out  18 core inputs {G18, G16..G0}, registered
//   BUSY   out  high in INIT and RUN
//   DONE   out  high in DONE
//   SIG    out  current signature
//   PASS   out  final signature equals GOLDEN_SIG (compare feature only)
module s832_bist_ctrl
    import s832_bist_pkg::*;
#(
    parameter int unsigned      N_PAT      = 256,
    parameter logic [PO_W-1:0]  GOLDEN_SIG = 19'h00000
) (
    input  logic            CK,
    input  logic            RST,
    input  logic            START,
    input  logic [PO_W-1:0] PO,
    output logic [PI_W-1:0] PI,
    output logic            BUSY,
    output logic            DONE,
    output logic [PO_W-1:0] SIG
`ifdef S832_BIST_GOLDEN_CMP_EN
    ,
    output logic            PASS
`endif
);

    localparam logic [15:0] LAST_PAT = 16'(N_PAT - 1);

    state_e              state, state_nxt;
    logic [LFSR_W-1:0]   lfsr, lfsr_nxt;
    logic [15:0]         cnt, cnt_nxt;
    logic [PI_W-1:0]     pi_q, pi_nxt;
    logic                misr_clr, misr_en;
    logic [PO_W-1:0]     misr_next;
    logic                last_pat;

    assign last_pat = (cnt == LAST_PAT);

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        cnt_nxt   = cnt;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        pi_nxt    = '0;
        case (state)
            ST_IDLE: if (START) state_nxt = ST_INIT;
            ST_INIT: begin
                state_nxt = ST_RUN;
                lfsr_nxt  = LFSR_SEED;
                cnt_nxt   = '0;
                misr_clr  = 1'b1;
            end
            ST_RUN: begin
                lfsr_nxt = lfsr_step(lfsr);
                cnt_nxt  = cnt + 16'd1;
                misr_en  = 1'b1;
                if (last_pat) state_nxt = ST_DONE;
            end
            ST_DONE: if (START) state_nxt = ST_INIT;
            default: state_nxt = ST_IDLE;
        endcase
        // PI is loaded from where the FSM is heading, so the pin value is a
        // plain flop output with no combinational path from START.
        case (state_nxt)
            ST_INIT: pi_nxt = {1'b1, {LFSR_W{1'b0}}};
            ST_RUN:  pi_nxt = {1'b0, lfsr_nxt};
            default: pi_nxt = '0;
        endcase
    end

    always_ff @(negedge CK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            lfsr  <= LFSR_SEED;
            cnt   <= '0;
            pi_q  <= '0;
        end else begin
            state <= state_nxt;
            lfsr  <= lfsr_nxt;
            cnt   <= cnt_nxt;
            pi_q  <= pi_nxt;
        end
    end

    s832_misr u_misr (
        .CK       (CK),
        .RST      (RST),
        .clr      (misr_clr),
        .en       (misr_en),
        .po       (PO),
        .sig      (SIG),
        .sig_next (misr_next)
    );

    assign PI   = pi_q;
    assign BUSY = (state == ST_INIT) || (state == ST_RUN);
    assign DONE = (state == ST_DONE);

`ifdef S832_BIST_GOLDEN_CMP_EN
    // Judged on the final RUN edge against the value the MISR is about to
    // take, so PASS and SIG become valid together on entry to DONE.
    always_ff @(negedge CK or posedge RST) begin
        if (RST) begin
            PASS <= 1'b0;
        end else if (state_nxt == ST_INIT) begin
            PASS <= 1'b0;
        end else if (state == ST_RUN && last_pat) begin
            PASS <= (misr_next == GOLDEN_SIG);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{GOLDEN_SIG, misr_next};
`endif

endmodule

// File: tb/tb_s832_bist_ctrl.sv
// tb_s832_bist_ctrl: scoreboard bench for s832_bist_ctrl. Three instances
// share clock, reset and START: u_a (N_PAT=2, PO=1, golden 3), u_b
// (N_PAT=256, driven by a small stand-in core), u_c (N_PAT=1, PO=1,
// golden 2). A reference model predicts every output each cycle.
module tb_s832_bist_ctrl;
    import s832_bist_pkg::*;

    logic        CK    = 1'b0;
    logic        RST   = 1'b1;
    logic        START = 1'b0;
    logic [18:0] po_const = 19'h00001;
    logic [18:0] po_b;
    logic [4:0]  core = '0;

    logic [17:0] pi_o   [3];
    logic [18:0] sig_o  [3];
    logic        busy_o [3];
    logic        done_o [3];
`ifdef S832_BIST_GOLDEN_CMP_EN
    logic        pass_o [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 CK = ~CK;

    s832_bist_ctrl #(.N_PAT(2), .GOLDEN_SIG(19'h00003)) u_a (
        .CK(CK), .RST(RST), .START(START), .PO(po_const),
        .PI(pi_o[0]), .BUSY(busy_o[0]), .DONE(done_o[0]), .SIG(sig_o[0])
`ifdef S832_BIST_GOLDEN_CMP_EN
        , .PASS(pass_o[0])
`endif
    );

    s832_bist_ctrl #(.N_PAT(256), .GOLDEN_SIG(19'h00000)) u_b (
        .CK(CK), .RST(RST), .START(START), .PO(po_b),
        .PI(pi_o[1]), .BUSY(busy_o[1]), .DONE(done_o[1]), .SIG(sig_o[1])
`ifdef S832_BIST_GOLDEN_CMP_EN
        , .PASS(pass_o[1])
`endif
    );

    s832_bist_ctrl #(.N_PAT(1), .GOLDEN_SIG(19'h00002)) u_c (
        .CK(CK), .RST(RST), .START(START), .PO(po_const),
        .PI(pi_o[2]), .BUSY(busy_o[2]), .DONE(done_o[2]), .SIG(sig_o[2])
`ifdef S832_BIST_GOLDEN_CMP_EN
        , .PASS(pass_o[2])
`endif
    );

    // Stand-in core: five flops cleared by G18, outputs mix flops and inputs.
    function automatic logic [4:0] core_next(input logic [4:0] c, input logic [17:0] pi);
        if (pi[17]) return 5'd0;
        return {c[3:0], c[4] ^ pi[0]} ^ pi[5:1];
    endfunction

    function automatic logic [18:0] core_po(input logic [4:0] c, input logic [17:0] pi);
        return {c[1:0], pi[16:0]} ^ {14'd0, c};
    endfunction

    always @(negedge CK) core <= core_next(core, pi_o[1]);
    assign po_b = core_po(core, pi_o[1]);

    // Reference model
    typedef struct {
        state_e      st;
        logic [16:0] lfsr;
        int          cnt;
        logic [18:0] misr;
        logic        pass;
        logic [4:0]  core;
    } mdl_t;

    typedef struct {
        int          inst;
        logic [17:0] pi;
        logic        busy;
        logic        done;
        logic [18:0] sig;
        logic        pass;
    } exp_t;

    mdl_t        mdl [3];
    int          n_pat_of [3] = '{2, 256, 1};
    logic [18:0] gold_of  [3] = '{19'h00003, 19'h00000, 19'h00002};
    exp_t        q [$];
    logic [18:0] sig_first;

    function automatic logic [17:0] mdl_pi(input mdl_t m);
        if (m.st == ST_INIT) return 18'h20000;
        if (m.st == ST_RUN)  return {1'b0, m.lfsr};
        return 18'h00000;
    endfunction

    function automatic mdl_t mdl_rst(input mdl_t m);
        mdl_t n = m;
        n.st = ST_IDLE; n.lfsr = 17'h00001; n.cnt = 0; n.misr = '0; n.pass = 1'b0;
        return n;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic start, input logic [18:0] po,
                                      input int n_pat, input logic [18:0] gold);
        mdl_t n = m;
        n.core = core_next(m.core, mdl_pi(m));
        case (m.st)
            ST_IDLE, ST_DONE: if (start) begin n.st = ST_INIT; n.pass = 1'b0; end
            ST_INIT: begin
                n.st = ST_RUN; n.lfsr = 17'h00001; n.cnt = 0; n.misr = '0; n.pass = 1'b0;
            end
            ST_RUN: begin
                n.misr = {m.misr[17:0], 1'b0} ^ (m.misr[18] ? 19'h00047 : 19'h0) ^ po;
                n.lfsr = {m.lfsr[15:0], m.lfsr[16] ^ m.lfsr[13]};
                n.cnt  = m.cnt + 1;
                if (m.cnt == n_pat - 1) begin
                    n.st   = ST_DONE;
                    n.pass = (n.misr == gold);
                end
            end
            default: n.st = ST_IDLE;
        endcase
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.inst = i;
            e.pi   = mdl_pi(mdl[i]);
            e.busy = (mdl[i].st == ST_INIT) || (mdl[i].st == ST_RUN);
            e.done = (mdl[i].st == ST_DONE);
            e.sig  = mdl[i].misr;
            e.pass = mdl[i].pass;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("c%0d u%0d pi",   cyc, e.inst), 32'(pi_o[e.inst]),   32'(e.pi));
            check($sformatf("c%0d u%0d busy", cyc, e.inst), 32'(busy_o[e.inst]), 32'(e.busy));
            check($sformatf("c%0d u%0d done", cyc, e.inst), 32'(done_o[e.inst]), 32'(e.done));
            check($sformatf("c%0d u%0d sig",  cyc, e.inst), 32'(sig_o[e.inst]),  32'(e.sig));
`ifdef S832_BIST_GOLDEN_CMP_EN
            check($sformatf("c%0d u%0d pass", cyc, e.inst), 32'(pass_o[e.inst]), 32'(e.pass));
`endif
        end
    endtask

    function automatic logic [18:0] mdl_po(input int i);
        if (i == 1) return core_po(mdl[1].core, mdl_pi(mdl[1]));
        return 19'h00001;
    endfunction

    // One falling edge: predict, let the DUT clock, compare half a period later.
    task automatic tick();
        for (int i = 0; i < 3; i++)
            mdl[i] = mdl_step(mdl[i], START, mdl_po(i), n_pat_of[i], gold_of[i]);
        push_exp();
        @(negedge CK);
        @(posedge CK);
        #1;
        cyc++;
        drain();
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 3; i++) begin
            mdl[i].core = '0;
            mdl[i] = mdl_rst(mdl[i]);
        end

        // Reset, then idle with START low
        repeat (2) @(posedge CK);
        #1 RST = 1'b0;
        push_exp();
        drain();
        repeat (10) tick();

        // Single START pulse: INIT, LFSR sequence, full runs of every instance
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (265) tick();
        sig_first = mdl[1].misr;
        check("a final sig", 32'(sig_o[0]), 32'h3);
        check("c final sig", 32'(sig_o[2]), 32'h1);
        check("b done",      32'(done_o[1]), 32'h1);
`ifdef S832_BIST_GOLDEN_CMP_EN
        check("a pass", 32'(pass_o[0]), 32'h1);
        check("c pass", 32'(pass_o[2]), 32'h0);
`endif

        // START held high; reset u_b while pattern 5 is on PI
        START = 1'b1;
        guard = 0;
        while (!(mdl[1].st == ST_RUN && mdl[1].cnt == 5) && guard < 300) begin
            tick();
            guard++;
        end
        check("reach pattern 5", 32'(guard < 300), 32'h1);
        #1 RST = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) mdl[i] = mdl_rst(mdl[i]);
        push_exp();
        drain();
        @(negedge CK);
        for (int i = 0; i < 3; i++)
            mdl[i] = mdl_rst(mdl_step(mdl[i], START, mdl_po(i), n_pat_of[i], gold_of[i]));
        @(posedge CK);
        #1 RST = 1'b0;
        push_exp();
        drain();

        // Continuous restart with START held: two more full runs of u_b
        repeat (600) begin
            tick();
            if (mdl[1].st == ST_DONE)
                check($sformatf("c%0d b resig", cyc), 32'(sig_o[1]), 32'(sig_first));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
